mul_cell_sequencer: RTL and testbench

//  Shares one 3-partial-product 16x16 multiply cell between NUM_REQ requesters (CPU cores).

---
 rtl/mul_seq_pkg.sv | 28 ++
 rtl/mul_rr_arbiter.sv | 49 ++++
 rtl/mul_cell_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mul_cell_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// ---------------------------------------------------------------------------
// mul_seq_pkg
//   Shared constants for the multiply-cell sequencer: datapath widths,
//   end-to-end latencies and the FSM state encoding used by the top level.
//   The states are plain localparam constants so that older tools and
//   netlists that expect a fixed binary encoding keep working.
//   Optional feature macro used by the design: MUL_HIGH_EN.
// ---------------------------------------------------------------------------
package mul_seq_pkg;

    // Datapath widths: full operand width and the half the cell multiplies.
    localparam int MUL_W  = 32;
    localparam int HALF_W = 16;

    // Accept-to-response latency in cycles, low-only and with the high word.
    localparam int LAT_LO = 3;
    localparam int LAT_HI = 4;

    // FSM state encoding.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ISSUE  = 3'd1;
    localparam state_t ST_SUM    = 3'd2;
    localparam state_t ST_SUM_HI = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

endpackage

// File: rtl/mul_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mul_rr_arbiter
//   Purely combinational round-robin pick: returns the first asserted
//   request at or after the pointer, wrapping around NUM_REQ.
// Ports
//   i_req    in   NUM_REQ  request vector
//   i_ptr    in   ID_W     index with highest priority this cycle
//   o_grant  out  NUM_REQ  one-hot grant (zero when nothing requests)
//   o_idx    out  ID_W     encoded index of the granted requester
//   o_any    out  1        at least one request is asserted
// ---------------------------------------------------------------------------
module mul_rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);

    // Each requester's distance from the pointer (mod NUM_REQ) is its
    // priority; the smallest distance among active requests wins. The
    // one-hot grant is then decoded from the winning index.
    always_comb begin
        int w_best;
        int w_dist;
        w_best  = NUM_REQ;
        w_dist  = 0;
        o_idx   = '0;
        o_grant = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            w_dist = j - int'(i_ptr);
            if (w_dist < 0) begin
                w_dist = w_dist + NUM_REQ;
            end
            if (i_req[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                o_idx  = ID_W'(j);
            end
        end
        o_any = (w_best < NUM_REQ);
        for (int j = 0; j < NUM_REQ; j++) begin
            o_grant[j] = o_any && (ID_W'(j) == o_idx);
        end
    end

endmodule

// File: rtl/mul_cell_sequencer.sv
// ---------------------------------------------------------------------------
// mul_cell_sequencer
//   Shares one 16x16 partial-product multiply cell between NUM_REQ cores.
//   Picks a requester round-robin, issues its operands to the cell, folds
//   the three partial products into the product and returns it on a
//   valid/ready response channel.
//   Optional macro MUL_HIGH_EN: also issues hi(a)*hi(b) and returns product
//   bits [63:32] on o_resp_hi (latency 4 instead of 3). Without it
//   o_resp_hi is tied to zero.
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_req_valid/o_req_ready   per-requester handshake (ready one-hot/zero)
//   i_req_a/i_req_b           operands, requester i at [32i+31:32i]
//   o_resp_valid/i_resp_ready response handshake
//   o_resp_id                 requester owning the response
//   o_resp_lo/o_resp_hi       product bits [31:0] / [63:32]
//   o_mul_en, o_mul_src1/2    to the shared cell
//   i_mul_p1/p2/p3            cell partials lo*lo, lo(a)*hi(b), hi(a)*lo(b)
// ---------------------------------------------------------------------------
module mul_cell_sequencer
    import mul_seq_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    output logic [NUM_REQ-1:0]     o_req_ready,
    input  logic [NUM_REQ*32-1:0]  i_req_a,
    input  logic [NUM_REQ*32-1:0]  i_req_b,
    output logic                   o_resp_valid,
    input  logic                   i_resp_ready,
    output logic [ID_W-1:0]        o_resp_id,
    output logic [31:0]            o_resp_lo,
    output logic [31:0]            o_resp_hi,
    output logic                   o_mul_en,
    output logic [31:0]            o_mul_src1,
    output logic [31:0]            o_mul_src2,
    input  logic [31:0]            i_mul_p1,
    input  logic [31:0]            i_mul_p2,
    input  logic [31:0]            i_mul_p3
);

    state_t                 r_state;
    logic [ID_W-1:0]        r_ptr;
    logic [ID_W-1:0]        r_id;
    logic [MUL_W-1:0]       r_a;
    logic [MUL_W-1:0]       r_b;
    logic [MUL_W-1:0]       r_lo;

    logic [NUM_REQ-1:0]     w_grant;
    logic [ID_W-1:0]        w_gidx;
    logic                   w_gany;
    logic [ID_W-1:0]        w_next_ptr;
    logic [MUL_W-1:0]       w_sel_a;
    logic [MUL_W-1:0]       w_sel_b;
    logic [MUL_W:0]         w_mid;
    logic [MUL_W:0]         w_lo_sum;

`ifdef MUL_HIGH_EN
    logic [MUL_W-1:0]       r_hi;
    logic [HALF_W:0]        r_mid_hi;
    logic                   r_carry;
`else
    logic                   w_unused_hi;
`endif

    mul_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_grant (w_grant),
        .o_idx   (w_gidx),
        .o_any   (w_gany)
    );

    // Operand mux for the granted requester, and the pointer value that
    // hands priority to the requester just after the one being granted.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (ID_W'(j) == w_gidx) begin
                w_sel_a = i_req_a[j*MUL_W +: MUL_W];
                w_sel_b = i_req_b[j*MUL_W +: MUL_W];
            end
        end
        w_next_ptr = (int'(w_gidx) == NUM_REQ - 1) ? '0 : w_gidx + ID_W'(1);
    end

    // Partial-product folding. The middle term is kept 33 bits wide and the
    // low sum keeps its carry out, so the high word (when enabled) receives
    // every carry that crosses bit 32.
    always_comb begin
        w_mid    = {1'b0, i_mul_p2} + {1'b0, i_mul_p3};
        w_lo_sum = {1'b0, i_mul_p1} + {1'b0, w_mid[HALF_W-1:0], {HALF_W{1'b0}}};
    end

`ifndef MUL_HIGH_EN
    assign w_unused_hi = ^{w_mid[MUL_W:HALF_W], w_lo_sum[MUL_W]};
`endif

    // Main sequencer: accept in IDLE, one issue cycle, fold the partials,
    // optionally fold the high word, then hold the response until consumed.
    // Reset from any state drops the operation without a response.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_id    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_lo    <= '0;
`ifdef MUL_HIGH_EN
            r_hi     <= '0;
            r_mid_hi <= '0;
            r_carry  <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_gany) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_gidx;
                        r_ptr   <= w_next_ptr;
                        r_state <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    r_state <= ST_SUM;
                end
                ST_SUM: begin
                    r_lo <= w_lo_sum[MUL_W-1:0];
`ifdef MUL_HIGH_EN
                    r_mid_hi <= w_mid[MUL_W:HALF_W];
                    r_carry  <= w_lo_sum[MUL_W];
                    r_state  <= ST_SUM_HI;
`else
                    r_state  <= ST_RESP;
`endif
                end
`ifdef MUL_HIGH_EN
                ST_SUM_HI: begin
                    r_hi    <= i_mul_p1 + {{(MUL_W-HALF_W-1){1'b0}}, r_mid_hi}
                                        + {{(MUL_W-1){1'b0}}, r_carry};
                    r_state <= ST_RESP;
                end
`endif
                ST_RESP: begin
                    if (i_resp_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Cell drive is decoded from the state: low halves in ISSUE, and with
    // the high feature the high halves in SUM. Everywhere else the cell is
    // idle with zero operands.
    always_comb begin
        o_mul_en   = 1'b0;
        o_mul_src1 = '0;
        o_mul_src2 = '0;
        case (r_state)
            ST_ISSUE: begin
                o_mul_en   = 1'b1;
                o_mul_src1 = r_a;
                o_mul_src2 = r_b;
            end
`ifdef MUL_HIGH_EN
            ST_SUM: begin
                o_mul_en   = 1'b1;
                o_mul_src1 = {{HALF_W{1'b0}}, r_a[MUL_W-1:HALF_W]};
                o_mul_src2 = {{HALF_W{1'b0}}, r_b[MUL_W-1:HALF_W]};
            end
`endif
            default: begin
                o_mul_en = 1'b0;
            end
        endcase
    end

    // Handshake and response outputs.
    assign o_req_ready  = (r_state == ST_IDLE) ? w_grant : '0;
    assign o_resp_valid = (r_state == ST_RESP);
    assign o_resp_id    = r_id;
    assign o_resp_lo    = r_lo;
`ifdef MUL_HIGH_EN
    assign o_resp_hi    = r_hi;
`else
    assign o_resp_hi    = '0;
`endif

endmodule

// File: tb/tb_mul_cell_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mul_cell_sequencer
//   Directed bench for the shared multiply-cell sequencer. A small
//   behavioural cell registers its three partial products on each mul_en.
//   Honors MUL_HIGH_EN to select expected high word and latency.
// ---------------------------------------------------------------------------
module tb_mul_cell_sequencer;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
`ifdef MUL_HIGH_EN
    localparam int LAT     = 4;
    localparam int PULSES  = 2;
    localparam bit HIGH    = 1'b1;
`else
    localparam int LAT     = 3;
    localparam int PULSES  = 1;
    localparam bit HIGH    = 1'b0;
`endif

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NUM_REQ-1:0]    reqValid;
    logic [NUM_REQ-1:0]    reqReady;
    logic [NUM_REQ*32-1:0] reqA;
    logic [NUM_REQ*32-1:0] reqB;
    logic                  respValid;
    logic                  respReady;
    logic [ID_W-1:0]       respId;
    logic [31:0]           respLo;
    logic [31:0]           respHi;
    logic                  mulEn;
    logic [31:0]           src1;
    logic [31:0]           src2;
    logic [31:0]           p1 = '0;
    logic [31:0]           p2 = '0;
    logic [31:0]           p3 = '0;

    int compareCount = 0;
    int failCount    = 0;
    int enCount      = 0;

    typedef struct {
        int          reqIdx;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] expLo;
        logic [31:0] expFullHi;
    } vec_t;

    vec_t vecs[8];

    mul_cell_sequencer #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) dut (
        .i_clk        (clk),
        .i_reset      (reset),
        .i_req_valid  (reqValid),
        .o_req_ready  (reqReady),
        .i_req_a      (reqA),
        .i_req_b      (reqB),
        .o_resp_valid (respValid),
        .i_resp_ready (respReady),
        .o_resp_id    (respId),
        .o_resp_lo    (respLo),
        .o_resp_hi    (respHi),
        .o_mul_en     (mulEn),
        .o_mul_src1   (src1),
        .o_mul_src2   (src2),
        .i_mul_p1     (p1),
        .i_mul_p2     (p2),
        .i_mul_p3     (p3)
    );

    // Free-running 10 ns clock.
    always #5 clk = ~clk;

    // Behavioural multiply cell: partials are registered on the enable edge.
    always @(posedge clk) begin
        if (mulEn === 1'b1) begin
            p1 <= {16'h0, src1[15:0]}  * {16'h0, src2[15:0]};
            p2 <= {16'h0, src1[15:0]}  * {16'h0, src2[31:16]};
            p3 <= {16'h0, src1[31:16]} * {16'h0, src2[15:0]};
        end
    end

    // Count every enable pulse the cell sees.
    always @(posedge clk) begin
        if (mulEn === 1'b1) begin
            enCount++;
        end
    end

    // Hard stop in case a sequence wedges.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        compareCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: actual=%h required=%h", name, actual, expected);
        end
    endtask

    // Runs one complete operation from requester reqIdx, starting and
    // ending at a falling edge with the sequencer idle and respReady high.
    task automatic applyStimulus(input int reqIdx, input logic [31:0] a,
                                 input logic [31:0] b, output int latency,
                                 output logic [31:0] lo, output logic [31:0] hi,
                                 output logic [ID_W-1:0] id, output int pulses);
        int startEn;
        int waitCycles;
        reqA[reqIdx*32 +: 32] = a;
        reqB[reqIdx*32 +: 32] = b;
        reqValid[reqIdx]      = 1'b1;
        #1;
        waitCycles = 0;
        while (reqReady[reqIdx] !== 1'b1 && waitCycles < 20) begin
            @(negedge clk);
            #1;
            waitCycles++;
        end
        checkOutput($sformatf("grant req%0d", reqIdx), 64'(reqReady[reqIdx]), 64'd1);
        startEn = enCount;
        @(posedge clk);
        @(negedge clk);
        reqValid[reqIdx] = 1'b0;
        latency = 1;
        while (respValid !== 1'b1 && latency < 20) begin
            @(negedge clk);
            latency++;
        end
        lo = respLo;
        hi = respHi;
        id = respId;
        @(posedge clk);
        @(negedge clk);
        pulses = enCount - startEn;
    endtask

    initial begin
        int             latency;
        int             pulses;
        int             got;
        int             cycles;
        logic [31:0]    lo;
        logic [31:0]    hi;
        logic [ID_W-1:0] id;

        vecs[0] = '{0, 32'h0001_0002, 32'h0003_0004, 32'h000A_0008, 32'h0000_0003};
        vecs[1] = '{0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32'hFFFF_FFFE};
        vecs[2] = '{1, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
        vecs[3] = '{1, 32'h0000_0001, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'h0000_0000};
        vecs[4] = '{0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 32'h0000_0001};
        vecs[5] = '{1, 32'h0000_FFFF, 32'h0000_FFFF, 32'hFFFE_0001, 32'h0000_0000};
        vecs[6] = '{0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0000, 32'h0000_0001};
        vecs[7] = '{1, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFE, 32'h0000_0001};

        reset     = 1'b1;
        reqValid  = '0;
        reqA      = '0;
        reqB      = '0;
        respReady = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;

        // Reset state.
        checkOutput("reset resp_valid", 64'(respValid), 64'd0);
        checkOutput("reset req_ready",  64'(reqReady),  64'd0);
        checkOutput("reset mul_en",     64'(mulEn),     64'd0);
        checkOutput("reset src",        {src1, src2},   64'd0);
        checkOutput("reset resp_data",  {respHi, respLo}, 64'd0);
        checkOutput("reset resp_id",    64'(respId),    64'd0);

        // Table-driven single operations.
        respReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].reqIdx, vecs[i].a, vecs[i].b, latency, lo, hi, id, pulses);
            checkOutput($sformatf("vec%0d lo", i), 64'(lo), 64'(vecs[i].expLo));
            checkOutput($sformatf("vec%0d hi", i), 64'(hi),
                        HIGH ? 64'(vecs[i].expFullHi) : 64'd0);
            checkOutput($sformatf("vec%0d id", i), 64'(id), 64'(vecs[i].reqIdx));
            checkOutput($sformatf("vec%0d latency", i), 64'(latency), 64'(LAT));
            checkOutput($sformatf("vec%0d mul_en pulses", i), 64'(pulses), 64'(PULSES));
        end

        // Two requesters held valid: grants must alternate starting at 0.
        begin
            int startEn;
            startEn = enCount;
            reqA[31:0]  = 32'd3;
            reqB[31:0]  = 32'd5;
            reqA[63:32] = 32'd7;
            reqB[63:32] = 32'd11;
            reqValid    = 2'b11;
            got    = 0;
            cycles = 0;
            while (got < 4 && cycles < 200) begin
                @(negedge clk);
                cycles++;
                if (respValid === 1'b1) begin
                    checkOutput($sformatf("alt%0d id", got), 64'(respId), 64'(got % 2));
                    checkOutput($sformatf("alt%0d lo", got), 64'(respLo),
                                (got % 2) ? 64'd77 : 64'd15);
                    got++;
                    if (got == 4) begin
                        reqValid = 2'b00;
                    end
                end
            end
            checkOutput("alt response count", 64'(got), 64'd4);
            @(negedge clk);
            @(negedge clk);
            checkOutput("alt mul_en pulses", 64'(enCount - startEn), 64'(4 * PULSES));
        end

        // Back-pressure: response held for five cycles, no new accept.
        respReady   = 1'b0;
        reqA[63:32] = 32'h0001_0002;
        reqB[63:32] = 32'h0003_0004;
        reqValid    = 2'b10;
        cycles = 0;
        while (respValid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("bp resp_valid seen", 64'(respValid), 64'd1);
        reqValid   = 2'b01;
        reqA[31:0] = 32'd9;
        reqB[31:0] = 32'd9;
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("bp%0d resp_valid", c), 64'(respValid), 64'd1);
            checkOutput($sformatf("bp%0d resp_lo", c), 64'(respLo), 64'h000A_0008);
            checkOutput($sformatf("bp%0d resp_hi", c), 64'(respHi), HIGH ? 64'd3 : 64'd0);
            checkOutput($sformatf("bp%0d resp_id", c), 64'(respId), 64'd1);
            checkOutput($sformatf("bp%0d req_ready", c), 64'(reqReady), 64'd0);
            checkOutput($sformatf("bp%0d mul_en", c), 64'(mulEn), 64'd0);
            @(negedge clk);
        end
        respReady = 1'b1;
        @(negedge clk);
        #1;
        checkOutput("bp release resp_valid", 64'(respValid), 64'd0);
        checkOutput("bp release req_ready",  64'(reqReady),  64'b01);
        reqValid = 2'b00;
        @(negedge clk);
        #1;
        checkOutput("bp dropped req mul_en", 64'(mulEn), 64'd0);
        checkOutput("bp dropped req_ready",  64'(reqReady), 64'd0);

        // Reset while in SUM: operation aborted, pointer back to zero.
        reqA[31:0] = 32'hFFFF_FFFF;
        reqB[31:0] = 32'hFFFF_FFFF;
        reqValid   = 2'b01;
        #1;
        cycles = 0;
        while (reqReady[0] !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            #1;
            cycles++;
        end
        checkOutput("rst grant req0", 64'(reqReady[0]), 64'd1);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst issue mul_en", 64'(mulEn), 64'd1);
        reqValid = 2'b00;
        @(negedge clk);
        checkOutput("rst sum mul_en", 64'(mulEn), 64'(HIGH));
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rst resp_valid", 64'(respValid), 64'd0);
        checkOutput("rst mul_en",     64'(mulEn),     64'd0);
        checkOutput("rst src",        {src1, src2},   64'd0);
        checkOutput("rst resp_data",  {respHi, respLo}, 64'd0);
        checkOutput("rst resp_id",    64'(respId),    64'd0);
        reset       = 1'b0;
        reqA[63:32] = 32'd2;
        reqB[63:32] = 32'd3;
        reqValid    = 2'b11;
        #1;
        checkOutput("rst ptr grant", 64'(reqReady), 64'b01);
        cycles = 0;
        while (respValid !== 1'b1 && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        checkOutput("rst first resp_id", 64'(respId), 64'd0);
        checkOutput("rst first resp_lo", 64'(respLo), 64'd1);
        checkOutput("rst first resp_hi", 64'(respHi), HIGH ? 64'hFFFF_FFFE : 64'd0);
        reqValid = 2'b00;
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
